peripheral_bfm_slave_axi4: RTL and testbench

Parametrised AXI4 slave bus functional model with a built-in word memory, used as the memory/peripheral endpoint in MPSoC DMA testbenches. Independent write and read engines accept one burst each at a time, support FIXED and INCR bursts up to 256 beats with byte strobes, and report SLVERR for unsupported or out-of-range accesses. It generalises the earlier fixed 32-bit, port-only slave BFM shell into a working, width- and depth-configurable model.

---
 rtl/peripheral_bfm_slave_axi4_if.sv | 62 ++++++
 rtl/peripheral_bfm_slave_axi4.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_peripheral_bfm_slave_axi4.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_bfm_slave_axi4_if.sv
// AXI4 slave BFM bus bundle: AW/W/B/AR/R channels with master and slave views.
interface peripheral_bfm_slave_axi4_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 4
) ();
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;
   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/peripheral_bfm_slave_axi4.sv
// AXI4 slave BFM with word memory: FIXED/INCR bursts, byte strobes, SLVERR on bad/out-of-range beats.
// Optional random wait states when PERIPHERAL_BFM_SLAVE_AXI4_WAIT_EN is defined.
module peripheral_bfm_slave_axi4 #(
   parameter int unsigned     DATA_WIDTH = 32,
   parameter int unsigned     ADDR_WIDTH = 32,
   parameter int unsigned     ID_WIDTH   = 4,
   parameter int unsigned     DEPTH      = 1024,
   parameter longint unsigned MEM_BASE   = 0
) (
   input logic                         aclk,
   input logic                         areset,
   peripheral_bfm_slave_axi4_if.slave  s_axi
);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned SHIFT  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(MEM_BASE);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   // Borrow bit of the widened subtraction flags addresses below MEM_BASE.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH:0] off;
      off = {1'b0, addr} - {1'b0, BASE};
      return !off[ADDR_WIDTH] && ((off[ADDR_WIDTH-1:0] >> SHIFT) < ADDR_WIDTH'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] index_of(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] word;
      word = (addr - BASE) >> SHIFT;
      return IDX_W'(word);
   endfunction

   function automatic logic bad_ctrl(input logic [1:0] burst, input logic [2:0] size);
      return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size > 3'(SHIFT));
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [1:0] burst,
                                                       input logic [2:0] size);
      return (burst == BURST_INCR) ? addr + (ADDR_WIDTH'(1) << size) : addr;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [1:0]            wait_seed;

`ifdef PERIPHERAL_BFM_SLAVE_AXI4_WAIT_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      wait_seed = lfsr_q[1:0];
   end

   always_ff @(posedge aclk) begin
      if (areset) lfsr_q <= 8'hA5;
      else        lfsr_q <= lfsr_d;
   end
`else
   always_comb wait_seed = 2'd0;
`endif

   // ---------------- write engine ----------------
   w_state_e              w_state_q, w_state_d;
   logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [ID_WIDTH-1:0]   bid_q, bid_d, w_id_q, w_id_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
   logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [2:0]            w_size_q, w_size_d;
   logic [1:0]            w_burst_q, w_burst_d, w_wait_q, w_wait_d;
   logic                  w_err_q, w_err_d, w_slverr_q, w_slverr_d;
   logic                  w_last_beat, w_beat_err, mem_we;
   logic [IDX_W-1:0]      mem_widx;

   always_comb begin
      w_state_d  = w_state_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      bid_d      = bid_q;
      w_id_d     = w_id_q;
      w_addr_d   = w_addr_q;
      w_len_d    = w_len_q;
      w_cnt_d    = w_cnt_q;
      w_size_d   = w_size_q;
      w_burst_d  = w_burst_q;
      w_wait_d   = w_wait_q;
      w_err_d    = w_err_q;
      w_slverr_d = w_slverr_q;
      mem_we     = 1'b0;
      mem_widx   = index_of(w_addr_q);
      w_last_beat = (w_cnt_q == w_len_q);
      w_beat_err  = w_err_q || !in_range(w_addr_q) || (s_axi.wlast != w_last_beat);
      case (w_state_q)
         W_IDLE: begin
            if (awready_q && s_axi.awvalid) begin
               w_state_d  = W_DATA;
               awready_d  = 1'b0;
               w_id_d     = s_axi.awid;
               w_addr_d   = s_axi.awaddr;
               w_len_d    = s_axi.awlen;
               w_size_d   = s_axi.awsize;
               w_burst_d  = s_axi.awburst;
               w_err_d    = bad_ctrl(s_axi.awburst, s_axi.awsize);
               w_cnt_d    = '0;
               w_slverr_d = 1'b0;
               wready_d   = (wait_seed == 2'd0);
               w_wait_d   = wait_seed;
            end else if (!awready_q) begin
               if (w_wait_q <= 2'd1) begin
                  awready_d = 1'b1;
                  w_wait_d  = '0;
               end else w_wait_d = w_wait_q - 2'd1;
            end
         end
         W_DATA: begin
            if (wready_q && s_axi.wvalid) begin
               mem_we     = !w_beat_err;
               w_slverr_d = w_slverr_q || w_beat_err;
               if (w_last_beat) begin
                  w_state_d = W_RESP;
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bid_d     = w_id_q;
                  bresp_d   = (w_slverr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  w_cnt_d  = w_cnt_q + 8'd1;
                  w_addr_d = next_addr(w_addr_q, w_burst_q, w_size_q);
                  wready_d = (wait_seed == 2'd0);
                  w_wait_d = wait_seed;
               end
            end else if (!wready_q) begin
               if (w_wait_q <= 2'd1) begin
                  wready_d = 1'b1;
                  w_wait_d = '0;
               end else w_wait_d = w_wait_q - 2'd1;
            end
         end
         W_RESP: begin
            if (bvalid_q && s_axi.bready) begin
               w_state_d = W_IDLE;
               bvalid_d  = 1'b0;
               awready_d = (wait_seed == 2'd0);
               w_wait_d  = wait_seed;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state_q  <= W_IDLE;
         awready_q  <= 1'b1;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= '0;
         bid_q      <= '0;
         w_id_q     <= '0;
         w_addr_q   <= '0;
         w_len_q    <= '0;
         w_cnt_q    <= '0;
         w_size_q   <= '0;
         w_burst_q  <= '0;
         w_wait_q   <= '0;
         w_err_q    <= 1'b0;
         w_slverr_q <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         bid_q      <= bid_d;
         w_id_q     <= w_id_d;
         w_addr_q   <= w_addr_d;
         w_len_q    <= w_len_d;
         w_cnt_q    <= w_cnt_d;
         w_size_q   <= w_size_d;
         w_burst_q  <= w_burst_d;
         w_wait_q   <= w_wait_d;
         w_err_q    <= w_err_d;
         w_slverr_q <= w_slverr_d;
      end
   end

   // Memory has no reset; a beat coinciding with areset is not committed.
   always_ff @(posedge aclk) begin
      if (mem_we && !areset) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (s_axi.wstrb[b]) mem_q[mem_widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   r_state_e              r_state_q, r_state_d;
   logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d, r_fetch_data;
   logic [1:0]            rresp_q, rresp_d, r_fetch_resp;
   logic [ID_WIDTH-1:0]   rid_q, rid_d;
   logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, r_next, r_fetch_addr;
   logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [2:0]            r_size_q, r_size_d;
   logic [1:0]            r_burst_q, r_burst_d, r_wait_q, r_wait_d;
   logic                  r_err_q, r_err_d, r_fetch_bad;

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rid_d     = rid_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_wait_d  = r_wait_q;
      r_err_d   = r_err_q;
      r_next    = next_addr(r_addr_q, r_burst_q, r_size_q);
      // One memory read port: the first beat comes from araddr, later beats from the advanced address.
      if (r_state_q == R_IDLE) begin
         r_fetch_addr = s_axi.araddr;
         r_fetch_bad  = bad_ctrl(s_axi.arburst, s_axi.arsize) || !in_range(s_axi.araddr);
      end else begin
         r_fetch_addr = r_next;
         r_fetch_bad  = r_err_q || !in_range(r_next);
      end
      r_fetch_data = r_fetch_bad ? '0 : mem_q[index_of(r_fetch_addr)];
      r_fetch_resp = r_fetch_bad ? RESP_SLVERR : RESP_OKAY;
      case (r_state_q)
         R_IDLE: begin
            if (arready_q && s_axi.arvalid) begin
               r_state_d = R_DATA;
               arready_d = 1'b0;
               rid_d     = s_axi.arid;
               r_addr_d  = s_axi.araddr;
               r_len_d   = s_axi.arlen;
               r_size_d  = s_axi.arsize;
               r_burst_d = s_axi.arburst;
               r_err_d   = bad_ctrl(s_axi.arburst, s_axi.arsize);
               r_cnt_d   = '0;
               rdata_d   = r_fetch_data;
               rresp_d   = r_fetch_resp;
               rlast_d   = (s_axi.arlen == 8'd0);
               rvalid_d  = (wait_seed == 2'd0);
               r_wait_d  = wait_seed;
            end else if (!arready_q) begin
               if (r_wait_q <= 2'd1) begin
                  arready_d = 1'b1;
                  r_wait_d  = '0;
               end else r_wait_d = r_wait_q - 2'd1;
            end
         end
         R_DATA: begin
            if (rvalid_q && s_axi.rready) begin
               if (rlast_q) begin
                  r_state_d = R_IDLE;
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = (wait_seed == 2'd0);
                  r_wait_d  = wait_seed;
               end else begin
                  r_addr_d = r_next;
                  r_cnt_d  = r_cnt_q + 8'd1;
                  rdata_d  = r_fetch_data;
                  rresp_d  = r_fetch_resp;
                  rlast_d  = (r_cnt_q + 8'd1 == r_len_q);
                  rvalid_d = (wait_seed == 2'd0);
                  r_wait_d = wait_seed;
               end
            end else if (!rvalid_q) begin
               if (r_wait_q <= 2'd1) begin
                  rvalid_d = 1'b1;
                  r_wait_d = '0;
               end else r_wait_d = r_wait_q - 2'd1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rid_q     <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_wait_q  <= '0;
         r_err_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rid_q     <= rid_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_wait_q  <= r_wait_d;
         r_err_q   <= r_err_d;
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rid     = rid_q;

endmodule

// File: tb/tb_peripheral_bfm_slave_axi4.sv
// Directed scoreboard bench for peripheral_bfm_slave_axi4 (default build, no wait states).
module tb_peripheral_bfm_slave_axi4;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned IW = 4;
   localparam int unsigned DEPTH = 64;
   localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } rbeat_t;

   logic aclk = 1'b0;
   logic areset;
   int   n_checks = 0;
   int   n_fails = 0;
   rbeat_t      rq[$];
   logic [1:0]  bq[$];
   logic [31:0] wd_q[$];
   logic [3:0]  ws_q[$];

   always #5 aclk = ~aclk;

   peripheral_bfm_slave_axi4_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

   peripheral_bfm_slave_axi4 #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(DEPTH), .MEM_BASE(64'd0)
   ) dut (
      .aclk(aclk), .areset(areset), .s_axi(bus.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_w(input logic [31:0] d, input logic [3:0] s);
      wd_q.push_back(d);
      ws_q.push_back(s);
   endtask

   task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last,
                         input logic [3:0] id);
      rbeat_t e;
      e.data = d; e.resp = resp; e.last = last; e.id = id;
      rq.push_back(e);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [3:0] id, input logic [1:0] exp_resp);
      int cnt;
      bq.push_back(exp_resp);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
      bus.awvalid = 1'b1;
      cnt = 0;
      while (!bus.awready && cnt < 64) begin @(negedge aclk); cnt++; end
      check("aw_handshake", bus.awready, 1);
      @(negedge aclk);
      bus.awvalid = 1'b0;
      check("wready_after_aw", bus.wready, 1);
      for (int i = 0; i <= int'(len); i++) begin
         bus.wdata = wd_q.pop_front();
         bus.wstrb = ws_q.pop_front();
         bus.wlast = (i == int'(len));
         bus.wvalid = 1'b1;
         cnt = 0;
         while (!bus.wready && cnt < 64) begin @(negedge aclk); cnt++; end
         check("w_handshake", bus.wready, 1);
         @(negedge aclk);
      end
      bus.wvalid = 1'b0;
      bus.wlast = 1'b0;
      check("bvalid_after_last", bus.bvalid, 1);
      check("bid", bus.bid, id);
      check("bresp", bus.bresp, bq.pop_front());
      bus.bready = 1'b1;
      @(negedge aclk);
      bus.bready = 1'b0;
      check("bvalid_cleared", bus.bvalid, 0);
      check("awready_restored", bus.awready, 1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] id, input int stall_beat);
      int cnt;
      int beat;
      rbeat_t e;
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
      bus.arvalid = 1'b1;
      cnt = 0;
      while (!bus.arready && cnt < 64) begin @(negedge aclk); cnt++; end
      check("ar_handshake", bus.arready, 1);
      @(negedge aclk);
      bus.arvalid = 1'b0;
      check("rvalid_after_ar", bus.rvalid, 1);
      bus.rready = 1'b1;
      beat = 0;
      cnt = 0;
      while (rq.size() > 0 && cnt < 400) begin
         if (bus.rvalid) begin
            if (beat == stall_beat) begin
               bus.rready = 1'b0;
               for (int k = 0; k < 5; k++) begin
                  @(negedge aclk);
                  check("stall_rvalid", bus.rvalid, 1);
                  check("stall_rdata", bus.rdata, rq[0].data);
                  check("stall_rlast", bus.rlast, rq[0].last);
               end
               bus.rready = 1'b1;
            end
            e = rq.pop_front();
            check("rdata", bus.rdata, e.data);
            check("rresp", bus.rresp, e.resp);
            check("rlast", bus.rlast, e.last);
            check("rid", bus.rid, e.id);
            beat++;
         end
         @(negedge aclk);
         cnt++;
      end
      bus.rready = 1'b0;
      check("rvalid_done", bus.rvalid, 0);
      check("arready_restored", bus.arready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      areset = 1'b1;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
      bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
      bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      repeat (3) @(negedge aclk);
      check("rst_awready", bus.awready, 1);
      check("rst_wready", bus.wready, 0);
      check("rst_bvalid", bus.bvalid, 0);
      check("rst_bresp", bus.bresp, 0);
      check("rst_bid", bus.bid, 0);
      check("rst_arready", bus.arready, 1);
      check("rst_rvalid", bus.rvalid, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_rresp", bus.rresp, 0);
      check("rst_rlast", bus.rlast, 0);
      check("rst_rid", bus.rid, 0);
      areset = 1'b0;
      @(negedge aclk);

      // INCR burst write then read back
      push_w(32'h11, 4'hF); push_w(32'h22, 4'hF); push_w(32'h33, 4'hF); push_w(32'h44, 4'hF);
      do_write(32'h10, 8'd3, INCR, 3'd2, 4'd3, OKAY);
      push_r(32'h11, OKAY, 1'b0, 4'd5); push_r(32'h22, OKAY, 1'b0, 4'd5);
      push_r(32'h33, OKAY, 1'b0, 4'd5); push_r(32'h44, OKAY, 1'b1, 4'd5);
      do_read(32'h10, 8'd3, INCR, 3'd2, 4'd5, -1);

      // partial strobes
      push_w(32'hAABBCCDD, 4'hF);
      do_write(32'h20, 8'd0, INCR, 3'd2, 4'd1, OKAY);
      push_w(32'h00000000, 4'b0101);
      do_write(32'h20, 8'd0, INCR, 3'd2, 4'd2, OKAY);
      push_r(32'hAA00CC00, OKAY, 1'b1, 4'd6);
      do_read(32'h20, 8'd0, INCR, 3'd2, 4'd6, -1);

      // FIXED burst keeps the last beat
      push_w(32'd1, 4'hF); push_w(32'd2, 4'hF); push_w(32'd3, 4'hF);
      do_write(32'h30, 8'd2, FIXED, 3'd2, 4'd7, OKAY);
      push_r(32'd3, OKAY, 1'b0, 4'd8); push_r(32'd3, OKAY, 1'b1, 4'd8);
      do_read(32'h30, 8'd1, FIXED, 3'd2, 4'd8, -1);

      // burst running off the top of memory
      push_w(32'hDEAD0001, 4'hF); push_w(32'hDEAD0002, 4'hF);
      do_write(32'h4 * (DEPTH - 1), 8'd1, INCR, 3'd2, 4'd9, SLVERR);
      push_r(32'hDEAD0001, OKAY, 1'b0, 4'd10); push_r(32'h0, SLVERR, 1'b1, 4'd10);
      do_read(32'h4 * (DEPTH - 1), 8'd1, INCR, 3'd2, 4'd10, -1);

      // WRAP is rejected and leaves memory untouched
      push_w(32'h5A5A0000, 4'hF); push_w(32'h5A5A0001, 4'hF);
      do_write(32'h40, 8'd1, INCR, 3'd2, 4'd1, OKAY);
      push_w(32'hFFFF0000, 4'hF); push_w(32'hFFFF0001, 4'hF);
      do_write(32'h40, 8'd1, WRAP, 3'd2, 4'd2, SLVERR);
      push_r(32'h5A5A0000, OKAY, 1'b0, 4'd3); push_r(32'h5A5A0001, OKAY, 1'b1, 4'd3);
      do_read(32'h40, 8'd1, INCR, 3'd2, 4'd3, -1);

      // oversize read
      push_r(32'h0, SLVERR, 1'b1, 4'd4);
      do_read(32'h10, 8'd0, INCR, 3'd3, 4'd4, -1);

      // rready stall mid-burst
      push_r(32'h11, OKAY, 1'b0, 4'd11); push_r(32'h22, OKAY, 1'b0, 4'd11);
      push_r(32'h33, OKAY, 1'b0, 4'd11); push_r(32'h44, OKAY, 1'b1, 4'd11);
      do_read(32'h10, 8'd3, INCR, 3'd2, 4'd11, 1);

      // reset during beat 2 of a 4-beat write
      bus.awid = 4'd15; bus.awaddr = 32'h60; bus.awlen = 8'd3; bus.awsize = 3'd2;
      bus.awburst = INCR; bus.awvalid = 1'b1;
      cnt = 0;
      while (!bus.awready && cnt < 64) begin @(negedge aclk); cnt++; end
      check("midrst_aw_handshake", bus.awready, 1);
      @(negedge aclk);
      bus.awvalid = 1'b0;
      bus.wdata = 32'h66660000; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      check("midrst_wready", bus.wready, 1);
      @(negedge aclk);
      bus.wdata = 32'h66660001;
      areset = 1'b1;
      @(negedge aclk);
      check("midrst_awready", bus.awready, 1);
      check("midrst_wready_low", bus.wready, 0);
      check("midrst_bvalid", bus.bvalid, 0);
      areset = 1'b0;
      bus.wvalid = 1'b0;
      @(negedge aclk);
      push_w(32'h70000000, 4'hF); push_w(32'h70000001, 4'hF);
      do_write(32'h70, 8'd1, INCR, 3'd2, 4'd12, OKAY);
      push_r(32'h66660000, OKAY, 1'b1, 4'd13);
      do_read(32'h60, 8'd0, INCR, 3'd2, 4'd13, -1);
      push_r(32'h70000000, OKAY, 1'b0, 4'd14); push_r(32'h70000001, OKAY, 1'b1, 4'd14);
      do_read(32'h70, 8'd1, INCR, 3'd2, 4'd14, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
